mul_arbiter: RTL and testbench
==============================

// Module: mul_arbiter
// PURPOSE
//   Shares one pipelined BW x BW unsigned multiplier between two requesters.
//   Each requester presents operands with a req/gnt handshake. The block arbitrates
//   round-robin, issues at most one operation per cycle, and tracks in-flight ops
//   with a tag pipeline. Each product is returned to its owner in a held response
//   register until that owner acknowledges it. Sits between client logic and the
//   multiplier datapath; the multiplier itself is external.
// PARAMETERS
//   BW       4  operand width; product width is 2*BW
//   MUL_LAT  2  edges from operands on mul_a/mul_b to matching product on mul_y (>=1)
// PORTS
//   CLK         in   1     clock, rising edge
//   RESET       in   1     asynchronous reset, active-high
//   req0/req1   in   1     operation request; held with operands until gnt
//   a0/a1       in   BW    operand a of requester 0/1
//   b0/b1       in   BW    operand b of requester 0/1
//   gnt0/gnt1   out  1     combinational; request accepted at this edge
//   rsp_valid0/1 out 1     product available, held until ack
//   rsp_y0/1    out  2*BW  product for requester 0/1
//   rsp_ack0/1  in   1     consumes the response when sampled with rsp_valid
//   mul_a/mul_b out  BW    registered operands to the multiplier
//   mul_y       in   2*BW  multiplier product
// BEHAVIOUR
// - One clock, CLK. Reset is asynchronous and active-high on RESET.
// - Reset values: gnt*=0, rsp_valid*=0, rsp_y*=0, mul_a=mul_b=0. All tags are invalid,
//   both slots are IDLE, and the rr pointer (last granted) is 1.
// - Per-requester slot FSM:
//     IDLE -> PEND  on gnt_i
//     PEND -> DONE  when a returning tag with id=i exits the pipeline
//     DONE -> IDLE  on rsp_ack_i
// - Eligibility: a requester is eligible when req_i=1 and its slot is IDLE. req_i in
//   PEND/DONE is ignored, with no gnt. Each requester has at most one op in flight.
// - Arbitration (combinational):
//     one eligible        -> grant it
//     both eligible       -> grant the one != last-granted
//   The pointer updates on every grant.
// - Issue edge: when gnt_i=1, mul_a<=a_i and mul_b<=b_i, and tag stage0<={1,i}. With
//   no grant, stage0<={0,x}. mul_a/mul_b hold their last value.
// - Tag pipeline is MUL_LAT+1 stages deep (stage0 aligned with mul_a/mul_b). When the
//   last stage is valid with id=i, rsp_y_i<=mul_y and rsp_valid_i<=1 at that edge.
// - Latency: gnt_i at edge E -> rsp_valid_i high after edge E+MUL_LAT+1 (MUL_LAT=2: 3
//   edges).
// - Throughput: one issue per cycle. Back-to-back grants to 0 then 1 give responses on
//   consecutive cycles.
// - rsp_ack_i with rsp_valid_i=0 is ignored. rsp_y_i is unchanged while DONE and
//   unchanged after ack.
// - A return and an ack for different slots in the same cycle are independent. A return
//   and an ack for the same slot cannot coincide (one op per slot).
// - Reset mid-operation: all in-flight tags are discarded and no response ever appears
//   for ops granted before reset.
// - Arithmetic: unsigned. Width 2*BW never overflows (15*15=225 at BW=4).
// STRUCTURE
// - Package mul_arb_pkg: slot state encoding (IDLE/PEND/DONE) and the tag struct
//   {valid, id}.
// - Sub-module mul_arb_rr2: 2-way round-robin arbiter with the pointer register.
// - Tag pipeline, slot FSMs and response registers live in mul_arbiter.
// - Verification uses a behavioural MUL_LAT-stage multiplier model.
// TESTING
// - Reset: RESET=1 -> all outputs 0. Release, no req -> no gnt, no rsp_valid.
// - Single op: req0, a0=6, b0=11 -> gnt0 the same cycle; rsp_valid0=1 with rsp_y0=66
//   after 3 edges; held until rsp_ack0, then cleared.
// - Contention: req0 (7,12) and req1 (8,13) together -> gnt0 then gnt1 on the next
//   cycle; rsp_y0=84 and rsp_y1=104 on consecutive cycles.
// - Fairness: both req held, acks immediate -> grants strictly alternate 0,1,0,1.
// - Blocking: req0 in DONE without ack -> no gnt0; req1 (15,15) still served with
//   rsp_y1=225.
// - Mid-flight reset: RESET pulsed 1 edge after gnt0 -> rsp_valid0 stays 0. A new req0
//   after release completes normally.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types for the two-requester multiplier arbiter: slot state
// encoding, the in-flight tag carried alongside the multiplier pipeline,
// and the round-robin pointer reset value.
package mul_arb_pkg;

    // Per-requester slot: free, waiting for its product, or holding it.
    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_PEND = 2'd1,
        SLOT_DONE = 2'd2
    } slot_state_e;

    // Travels with each issued operation so the product can be routed home.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    // Pointer holds the last granted requester; starting at 1 favours 0 first.
    localparam logic RR_RESET_LAST = 1'b1;

endpackage

// File: rtl/mul_arbiter_if.sv
// One requester's connection to the arbiter.
// Handshakes: an operation transfers on a rising edge where req=1 and gnt=1
// (req and operands stay stable until then); a response transfers on a rising
// edge where rsp_valid=1 and rsp_ack=1 (rsp_y stays stable until then).
interface mul_arbiter_if #(
    parameter int BW = 4
);
    logic            req;
    logic [BW-1:0]   a;
    logic [BW-1:0]   b;
    logic            gnt;
    logic            rsp_valid;
    logic [2*BW-1:0] rsp_y;
    logic            rsp_ack;

    modport master (output req, a, b, rsp_ack, input gnt, rsp_valid, rsp_y);
    modport slave  (input req, a, b, rsp_ack, output gnt, rsp_valid, rsp_y);
endinterface

// File: rtl/mul_arb_rr2.sv
// Two-way round-robin arbiter. The pointer remembers the last granted
// requester; on a tie the other one wins.
module mul_arb_rr2
    import mul_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    output logic [1:0] gnt,
    output logic       last_o
);

    logic last_q;
    logic last_d;

    // Grant selection and pointer update on any grant.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        gnt[0] = elig[0] & (~elig[1] | last_q);
        gnt[1] = elig[1] & (~elig[0] | ~last_q);
        if (gnt[1]) begin
            last_d = 1'b1;
        end else if (gnt[0]) begin
            last_d = 1'b0;
        end
    end

    // Last-granted pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= RR_RESET_LAST;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external pipelined multiplier between two requesters. A tag
// pipeline of MUL_LAT+1 stages runs beside the multiplier so each product
// lands in its owner's held response register.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int BW      = 4,
    parameter int MUL_LAT = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    mul_arbiter_if.slave    p0,
    mul_arbiter_if.slave    p1,
    output logic [BW-1:0]   mul_a,
    output logic [BW-1:0]   mul_b,
    input  logic [2*BW-1:0] mul_y,
    output logic [1:0]      dbg_slot0,
    output logic [1:0]      dbg_slot1,
    output logic            dbg_rr_last
);

    logic [1:0] req;
    logic [1:0] ack;
    logic [1:0] elig;
    logic [1:0] gnt;
    logic [1:0] ret_hit;

    slot_state_e     state_q [2];
    slot_state_e     state_d [2];
    logic [2*BW-1:0] rsp_y_q [2];
    logic [2*BW-1:0] rsp_y_d [2];
    tag_t            tag_q   [MUL_LAT+1];
    tag_t            tag_d   [MUL_LAT+1];
    logic [BW-1:0]   mul_a_q, mul_a_d;
    logic [BW-1:0]   mul_b_q, mul_b_d;

    assign req = {p1.req, p0.req};
    assign ack = {p1.rsp_ack, p0.rsp_ack};

    // A slot may only take a new op when free; nothing is granted in reset.
    always_comb begin
        elig    = 2'b00;
        elig[0] = req[0] & (state_q[0] == SLOT_IDLE) & ~RESET;
        elig[1] = req[1] & (state_q[1] == SLOT_IDLE) & ~RESET;
    end

    mul_arb_rr2 u_rr (
        .clk    (CLK),
        .rst    (RESET),
        .elig   (elig),
        .gnt    (gnt),
        .last_o (dbg_rr_last)
    );

    // Issue operands of the granted requester; hold them otherwise.
    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (gnt[1]) begin
            mul_a_d = p1.a;
            mul_b_d = p1.b;
        end else if (gnt[0]) begin
            mul_a_d = p0.a;
            mul_b_d = p0.b;
        end
    end

    // Tag pipeline: stage0 is aligned with mul_a/mul_b, last stage with mul_y.
    always_comb begin
        for (int k = 0; k <= MUL_LAT; k++) begin
            tag_d[k] = tag_q[k];
        end
        tag_d[0].valid = |gnt;
        tag_d[0].id    = gnt[1];
        for (int k = 1; k <= MUL_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Which slot the product currently on mul_y belongs to.
    always_comb begin
        ret_hit    = 2'b00;
        ret_hit[0] = tag_q[MUL_LAT].valid & ~tag_q[MUL_LAT].id;
        ret_hit[1] = tag_q[MUL_LAT].valid &  tag_q[MUL_LAT].id;
    end

    // Slot FSMs and response capture.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            rsp_y_d[i] = rsp_y_q[i];
            unique case (state_q[i])
                SLOT_IDLE: if (gnt[i]) state_d[i] = SLOT_PEND;
                SLOT_PEND: begin
                    if (ret_hit[i]) begin
                        state_d[i] = SLOT_DONE;
                        rsp_y_d[i] = mul_y;
                    end
                end
                SLOT_DONE: if (ack[i]) state_d[i] = SLOT_IDLE;
                default:   state_d[i] = SLOT_IDLE;
            endcase
        end
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= SLOT_IDLE;
                rsp_y_q[i] <= '0;
            end
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                rsp_y_q[i] <= rsp_y_d[i];
            end
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign p0.gnt       = gnt[0];
    assign p1.gnt       = gnt[1];
    assign p0.rsp_valid = (state_q[0] == SLOT_DONE);
    assign p1.rsp_valid = (state_q[1] == SLOT_DONE);
    assign p0.rsp_y     = rsp_y_q[0];
    assign p1.rsp_y     = rsp_y_q[1];
    assign dbg_slot0    = state_q[0];
    assign dbg_slot1    = state_q[1];

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed vector table, hand sequences for the
// mid-flight reset and fairness cases, and a randomized run against an
// event-list reference model.
module tb_mul_arbiter;

    localparam int BW      = 4;
    localparam int MUL_LAT = 2;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [BW-1:0]   mul_a, mul_b;
    logic [2*BW-1:0] mul_y;
    logic [1:0]      dbg_slot0, dbg_slot1;
    logic            dbg_rr_last;
    logic [2*BW-1:0] mpipe [MUL_LAT];

    mul_arbiter_if #(.BW(BW)) if0 ();
    mul_arbiter_if #(.BW(BW)) if1 ();

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    mul_arbiter #(.BW(BW), .MUL_LAT(MUL_LAT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .p0          (if0.slave),
        .p1          (if1.slave),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_y       (mul_y),
        .dbg_slot0   (dbg_slot0),
        .dbg_slot1   (dbg_slot1),
        .dbg_rr_last (dbg_rr_last)
    );

    // Behavioural MUL_LAT-stage multiplier.
    always @(posedge CLK) begin
        mpipe[0] <= (2*BW)'(mul_a) * (2*BW)'(mul_b);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_y = mpipe[MUL_LAT-1];

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_in(input int r0, input int a0, input int b0, input int k0,
                          input int r1, input int a1, input int b1, input int k1);
        if0.req = 1'(r0); if0.a = BW'(a0); if0.b = BW'(b0); if0.rsp_ack = 1'(k0);
        if1.req = 1'(r1); if1.a = BW'(a1); if1.b = BW'(b1); if1.rsp_ack = 1'(k1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Each granted op becomes an event due MUL_LAT+1 edges later; a slot is
    // busy from grant until its response is acknowledged.
    typedef struct {
        int due;
        int id;
        int prod;
    } pend_t;

    pend_t pend_q[$];
    int    m_busy [2];
    int    m_v    [2];
    int    m_y    [2];
    int    m_last;
    int    edge_n;
    int    obs_g0, obs_g1;

    task automatic model_init();
        pend_q.delete();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_v[i] = 0; m_y[i] = 0;
        end
        m_last = 1;
        edge_n = 0;
    endtask

    // Called just after a negedge with inputs already set.
    task automatic model_step();
        int e0, e1, g0, g1, a0, b0, a1, b1, k0, k1;
        #1;
        e0 = (if0.req === 1'b1) && (m_busy[0] == 0);
        e1 = (if1.req === 1'b1) && (m_busy[1] == 0);
        g0 = e0 && (!e1 || m_last == 1);
        g1 = e1 && (!e0 || m_last == 0);
        chk("m_gnt0", 32'(if0.gnt), g0);
        chk("m_gnt1", 32'(if1.gnt), g1);
        chk("m_rsp_valid0", 32'(if0.rsp_valid), m_v[0]);
        chk("m_rsp_valid1", 32'(if1.rsp_valid), m_v[1]);
        chk("m_rsp_y0", 32'(if0.rsp_y), m_y[0]);
        chk("m_rsp_y1", 32'(if1.rsp_y), m_y[1]);
        obs_g0 = int'(if0.gnt); obs_g1 = int'(if1.gnt);
        a0 = int'(if0.a); b0 = int'(if0.b); a1 = int'(if1.a); b1 = int'(if1.b);
        k0 = int'(if0.rsp_ack); k1 = int'(if1.rsp_ack);
        @(posedge CLK);
        edge_n++;
        if (m_v[0] != 0 && k0 != 0) begin m_v[0] = 0; m_busy[0] = 0; end
        if (m_v[1] != 0 && k1 != 0) begin m_v[1] = 0; m_busy[1] = 0; end
        for (int j = pend_q.size() - 1; j >= 0; j--) begin
            if (pend_q[j].due == edge_n) begin
                m_v[pend_q[j].id] = 1;
                m_y[pend_q[j].id] = pend_q[j].prod;
                pend_q.delete(j);
            end
        end
        if (g0 != 0) begin
            m_busy[0] = 1; m_last = 0;
            pend_q.push_back('{edge_n + MUL_LAT + 1, 0, a0 * b0});
        end
        if (g1 != 0) begin
            m_busy[1] = 1; m_last = 1;
            pend_q.push_back('{edge_n + MUL_LAT + 1, 1, a1 * b1});
        end
        @(negedge CLK);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int r0, a0, b0, k0;
        int r1, a1, b1, k1;
        int g0, g1, v0, y0, v1, y1;
    } vec_t;

    vec_t tbl [22];

    initial begin
        int last_g, g, gcount;

        // contention: 0 wins first (pointer resets to 1), then 1
        tbl[0]  = '{1,7,12,0,  1,8,13,0,   1,0, 0,0,  0,0};
        tbl[1]  = '{1,7,12,0,  1,8,13,0,   0,1, 0,0,  0,0};
        tbl[2]  = '{0,0,0,0,   0,0,0,0,    0,0, 0,0,  0,0};
        tbl[3]  = '{0,0,0,0,   0,0,0,0,    0,0, 0,0,  0,0};
        tbl[4]  = '{0,0,0,0,   0,0,0,0,    0,0, 1,84, 0,0};
        tbl[5]  = '{0,0,0,1,   0,0,0,0,    0,0, 1,84, 1,104};
        // single op 6*11 right after slot 0 frees
        tbl[6]  = '{1,6,11,0,  0,0,0,1,    1,0, 0,84, 1,104};
        tbl[7]  = '{0,0,0,0,   0,0,0,0,    0,0, 0,84, 0,104};
        tbl[8]  = '{0,0,0,0,   0,0,0,0,    0,0, 0,84, 0,104};
        tbl[9]  = '{0,0,0,0,   0,0,0,0,    0,0, 0,84, 0,104};
        tbl[10] = '{0,0,0,0,   0,0,0,0,    0,0, 1,66, 0,104};
        tbl[11] = '{0,0,0,1,   0,0,0,0,    0,0, 1,66, 0,104};
        // blocking: slot 0 held in PEND/DONE ignores req0, req1 still served
        tbl[12] = '{1,3,3,0,   0,0,0,0,    1,0, 0,66, 0,104};
        tbl[13] = '{1,5,5,0,   0,0,0,0,    0,0, 0,66, 0,104};
        tbl[14] = '{0,0,0,0,   0,0,0,0,    0,0, 0,66, 0,104};
        tbl[15] = '{0,0,0,0,   0,0,0,0,    0,0, 0,66, 0,104};
        tbl[16] = '{1,2,2,0,   1,15,15,0,  0,1, 1,9,  0,104};
        tbl[17] = '{1,2,2,0,   0,0,0,0,    0,0, 1,9,  0,104};
        tbl[18] = '{1,2,2,0,   0,0,0,0,    0,0, 1,9,  0,104};
        tbl[19] = '{1,2,2,0,   0,0,0,0,    0,0, 1,9,  0,104};
        tbl[20] = '{1,2,2,1,   0,0,0,1,    0,0, 1,9,  1,225};
        tbl[21] = '{1,2,2,0,   0,0,0,0,    1,0, 0,9,  0,225};

        // reset values
        RESET = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_gnt0", 32'(if0.gnt), 0);
        chk("rst_gnt1", 32'(if1.gnt), 0);
        chk("rst_valid0", 32'(if0.rsp_valid), 0);
        chk("rst_valid1", 32'(if1.rsp_valid), 0);
        chk("rst_y0", 32'(if0.rsp_y), 0);
        chk("rst_y1", 32'(if1.rsp_y), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_b", 32'(mul_b), 0);
        RESET = 1'b0;

        // idle after release
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("idle_gnt", 32'({if1.gnt, if0.gnt}), 0);
            chk("idle_valid", 32'({if1.rsp_valid, if0.rsp_valid}), 0);
            @(posedge CLK);
            @(negedge CLK);
        end

        // vector table
        for (int i = 0; i < 22; i++) begin
            set_in(tbl[i].r0, tbl[i].a0, tbl[i].b0, tbl[i].k0,
                   tbl[i].r1, tbl[i].a1, tbl[i].b1, tbl[i].k1);
            #1;
            chk($sformatf("v%0d_gnt0", i), 32'(if0.gnt), tbl[i].g0);
            chk($sformatf("v%0d_gnt1", i), 32'(if1.gnt), tbl[i].g1);
            chk($sformatf("v%0d_valid0", i), 32'(if0.rsp_valid), tbl[i].v0);
            chk($sformatf("v%0d_y0", i), 32'(if0.rsp_y), tbl[i].y0);
            chk($sformatf("v%0d_valid1", i), 32'(if1.rsp_valid), tbl[i].v1);
            chk($sformatf("v%0d_y1", i), 32'(if1.rsp_y), tbl[i].y1);
            @(posedge CLK);
            @(negedge CLK);
        end

        // mid-flight reset: op granted, reset one edge later, never returns
        do_reset();
        set_in(1, 4, 4, 0, 0, 0, 0, 0);
        #1;
        chk("mid_gnt0", 32'(if0.gnt), 1);
        @(posedge CLK);
        @(negedge CLK);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        RESET = 1'b1;
        #1;
        chk("mid_rst_mul_a", 32'(mul_a), 0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_init();
        repeat (8) model_step();
        set_in(1, 5, 6, 0, 0, 0, 0, 0);
        model_step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) model_step();
        #1;
        chk("mid_new_valid0", 32'(if0.rsp_valid), 1);
        chk("mid_new_y0", 32'(if0.rsp_y), 30);
        set_in(0, 0, 0, 1, 0, 0, 0, 0);
        model_step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_step();

        // fairness: both held, acks immediate -> strict alternation
        do_reset();
        model_init();
        last_g = -1;
        gcount = 0;
        for (int c = 0; c < 40; c++) begin
            set_in(1, $urandom_range(0, 15), $urandom_range(0, 15), 1,
                   1, $urandom_range(0, 15), $urandom_range(0, 15), 1);
            model_step();
            if (obs_g0 != 0 || obs_g1 != 0) begin
                g = obs_g1;
                if (last_g >= 0) chk("fair_alternate", 32'(g), 32'(1 - last_g));
                last_g = g;
                gcount++;
            end
        end
        chk("fair_grant_count_ge10", 32'(gcount >= 10), 1);

        // randomized traffic against the model
        do_reset();
        model_init();
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 1),
                   ($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 1));
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
